// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control encoding
//
// Purpose: operation-select width and alu_ctrl code points, shared by the
// datapath and any control decoder that drives alu_ctrl.
package alu_pkg;

    localparam int ALU_CTRL_W = 3;

    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_AND = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_OR  = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_ADD = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SUB = 3'b110;
    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SLT = 3'b111;

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - combinational ALU datapath
//
// Purpose: operation mux, adder/subtractor, signed compare and zero detect.
// Ports:
//   a, b      xlen-bit operands (two's complement for signed ops)
//   alu_ctrl  operation select (see alu_pkg)
//   result    xlen-bit operation result
//   zero      1 when result is all zeros
module alu_comb
    import alu_pkg::*;
#(
    parameter int xlen = 64
) (
    input  logic [xlen-1:0]       a,
    input  logic [xlen-1:0]       b,
    input  logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [xlen-1:0]       result,
    output logic                  zero
);

    logic [xlen-1:0] sum;
    logic [xlen-1:0] diff;
    logic            less;

    // Carry/borrow out of the top bit is simply dropped by the width.
    assign sum  = a + b;
    assign diff = a - b;

    // True signed compare, so the answer stays right when a - b overflows.
    assign less = $signed(a) < $signed(b);

    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_CTRL_AND: result = a & b;
            ALU_CTRL_OR:  result = a | b;
            ALU_CTRL_ADD: result = sum;
            ALU_CTRL_SUB: result = diff;
            ALU_CTRL_SLT: result = {{(xlen-1){1'b0}}, less};
            default:      result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - integer ALU with registered result/zero copy
//
// Purpose: combinational ALU plus a one-cycle-delayed view for pipelined
// consumers.
// Ports:
//   clk       system clock; rising edge loads result_q/zero_q
//   rst_n     asynchronous active-low reset of the registered outputs
//   a, b      xlen-bit operands
//   alu_ctrl  operation select (see alu_pkg)
//   result    combinational result, independent of clk/rst_n
//   zero      combinational, 1 when result == 0
//   result_q  result registered on rising clk (0 in reset)
//   zero_q    zero registered on rising clk (1 in reset)
module alu
    import alu_pkg::*;
#(
    parameter int xlen = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [xlen-1:0]       a,
    input  logic [xlen-1:0]       b,
    input  logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [xlen-1:0]       result,
    output logic                  zero,
    output logic [xlen-1:0]       result_q,
    output logic                  zero_q
);

    alu_comb #(
        .xlen(xlen)
    ) u_comb (
        .a       (a),
        .b       (b),
        .alu_ctrl(alu_ctrl),
        .result  (result),
        .zero    (zero)
    );

    // Reset value mirrors a zero result so zero_q is consistent with result_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result;
            zero_q   <= zero;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu
module tb_alu;
    import alu_pkg::*;

    localparam logic [63:0] MAX_POS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic [2:0]  alu_ctrl = '0;
    logic [63:0] result;
    logic        zero;
    logic [63:0] result_q;
    logic        zero_q;

    int checks = 0;
    int failures = 0;

    alu #(.xlen(64)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .alu_ctrl(alu_ctrl),
        .result  (result),
        .zero    (zero),
        .result_q(result_q),
        .zero_q  (zero_q)
    );

    always #5 clk = ~clk;

    // Reference model: arithmetic straight from the operation table.
    function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                          input logic [2:0] op);
        longint sx;
        longint sy;
        sx = longint'(x);
        sy = longint'(y);
        case (op)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x + y;
            3'b110:  return x - y;
            3'b111:  return (sx < sy) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    task automatic test_reset();
        a = 64'd5; b = 64'd10; alu_ctrl = ALU_CTRL_ADD;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (result_q !== 64'd0 || zero_q !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold result_q=%h zero_q=%b expected 0 1", result_q, zero_q);
        end
        checks++;
        if (result !== 64'd15 || zero !== 1'b0) begin
            failures++;
            $display("FAIL comb_in_reset result=%h zero=%b expected f 0", result, zero);
        end
    endtask

    task automatic test_logic();
        a = 64'b1010; b = 64'b0101;
        alu_ctrl = ALU_CTRL_AND; #1;
        checks++;
        if (result !== 64'd0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL and result=%h zero=%b expected 0 1", result, zero);
        end
        alu_ctrl = ALU_CTRL_OR; #1;
        checks++;
        if (result !== 64'hF || zero !== 1'b0) begin
            failures++;
            $display("FAIL or result=%h zero=%b expected f 0", result, zero);
        end
    endtask

    task automatic test_add();
        logic [63:0] av[4];
        logic [63:0] bv[4];
        logic [63:0] ev[4];
        logic        zv[4];
        av[0] = 64'd5;     bv[0] = 64'd10; ev[0] = 64'd15;      zv[0] = 1'b0;
        av[1] = -64'sd50;  bv[1] = 64'd10; ev[1] = -64'sd40;    zv[1] = 1'b0;
        av[2] = ONES;      bv[2] = 64'd1;  ev[2] = 64'd0;       zv[2] = 1'b1;
        av[3] = MAX_POS;   bv[3] = 64'd1;  ev[3] = MIN_NEG;     zv[3] = 1'b0;
        alu_ctrl = ALU_CTRL_ADD;
        for (int i = 0; i < 4; i++) begin
            a = av[i]; b = bv[i]; #1;
            checks++;
            if (result !== ev[i] || zero !== zv[i]) begin
                failures++;
                $display("FAIL add[%0d] result=%h zero=%b expected %h %b",
                         i, result, zero, ev[i], zv[i]);
            end
        end
    endtask

    task automatic test_sub();
        logic [63:0] av[3];
        logic [63:0] bv[3];
        logic [63:0] ev[3];
        logic        zv[3];
        av[0] = 64'd5;   bv[0] = 64'd6;  ev[0] = ONES;    zv[0] = 1'b0;
        av[1] = 64'd102; bv[1] = 64'd22; ev[1] = 64'd80;  zv[1] = 1'b0;
        av[2] = MIN_NEG; bv[2] = MIN_NEG; ev[2] = 64'd0;  zv[2] = 1'b1;
        alu_ctrl = ALU_CTRL_SUB;
        for (int i = 0; i < 3; i++) begin
            a = av[i]; b = bv[i]; #1;
            checks++;
            if (result !== ev[i] || zero !== zv[i]) begin
                failures++;
                $display("FAIL sub[%0d] result=%h zero=%b expected %h %b",
                         i, result, zero, ev[i], zv[i]);
            end
        end
    endtask

    task automatic test_slt();
        logic [63:0] av[6];
        logic [63:0] bv[6];
        logic [63:0] ev[6];
        av[0] = 64'd0;   bv[0] = 64'd0;   ev[0] = 64'd0;
        av[1] = 64'd5;   bv[1] = 64'd10;  ev[1] = 64'd1;
        av[2] = ONES;    bv[2] = 64'd0;   ev[2] = 64'd1;
        av[3] = 64'd0;   bv[3] = ONES;    ev[3] = 64'd0;
        av[4] = MIN_NEG; bv[4] = MAX_POS; ev[4] = 64'd1;
        av[5] = MAX_POS; bv[5] = MIN_NEG; ev[5] = 64'd0;
        alu_ctrl = ALU_CTRL_SLT;
        for (int i = 0; i < 6; i++) begin
            a = av[i]; b = bv[i]; #1;
            checks++;
            if (result !== ev[i] || zero !== (ev[i] == 64'd0)) begin
                failures++;
                $display("FAIL slt[%0d] result=%h zero=%b expected %h", i, result, zero, ev[i]);
            end
        end
    endtask

    task automatic test_unused();
        logic [2:0] codes[3];
        codes[0] = 3'b011; codes[1] = 3'b100; codes[2] = 3'b101;
        a = ONES; b = ONES;
        for (int i = 0; i < 3; i++) begin
            alu_ctrl = codes[i]; #1;
            checks++;
            if (result !== 64'd0 || zero !== 1'b1) begin
                failures++;
                $display("FAIL unused[%b] result=%h zero=%b expected 0 1", codes[i], result, zero);
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        rst_n = 1'b1;
        a = 64'd5; b = 64'd10; alu_ctrl = ALU_CTRL_ADD;
        @(posedge clk); #1;
        checks++;
        if (result_q !== 64'd15 || zero_q !== 1'b0) begin
            failures++;
            $display("FAIL reg_add result_q=%h zero_q=%b expected f 0", result_q, zero_q);
        end
        @(negedge clk);
        alu_ctrl = ALU_CTRL_SUB; b = 64'd5;
        #1;
        checks++;
        if (result_q !== 64'd15) begin
            failures++;
            $display("FAIL reg_latency result_q=%h expected f", result_q);
        end
        @(posedge clk); #1;
        checks++;
        if (result_q !== 64'd0 || zero_q !== 1'b1) begin
            failures++;
            $display("FAIL reg_sub result_q=%h zero_q=%b expected 0 1", result_q, zero_q);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a = 64'd7; b = 64'd1; alu_ctrl = ALU_CTRL_OR;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (result_q !== 64'd0 || zero_q !== 1'b1) begin
            failures++;
            $display("FAIL async_reset result_q=%h zero_q=%b expected 0 1", result_q, zero_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (result_q !== 64'd7 || zero_q !== 1'b0) begin
            failures++;
            $display("FAIL resume result_q=%h zero_q=%b expected 7 0", result_q, zero_q);
        end
    endtask

    task automatic test_random();
        logic [63:0] special[5];
        logic [63:0] exp_r;
        special[0] = 64'd0; special[1] = ONES; special[2] = MAX_POS;
        special[3] = MIN_NEG; special[4] = 64'd1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = special[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) b = special[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0) b = a;
            alu_ctrl = 3'($urandom_range(0, 7));
            exp_r = model(a, b, alu_ctrl);
            #1;
            checks++;
            if (result !== exp_r || zero !== (exp_r == 64'd0)) begin
                failures++;
                $display("FAIL rand_comb[%0d] op=%b a=%h b=%h result=%h zero=%b expected %h",
                         i, alu_ctrl, a, b, result, zero, exp_r);
            end
            @(posedge clk); #1;
            checks++;
            if (result_q !== exp_r || zero_q !== (exp_r == 64'd0)) begin
                failures++;
                $display("FAIL rand_reg[%0d] result_q=%h zero_q=%b expected %h",
                         i, result_q, zero_q, exp_r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_logic();
        test_add();
        test_sub();
        test_slt();
        test_unused();
        test_registered();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
